fir_axilite_cfg: RTL and testbench

- AXI-lite responder that owns the FIR configuration space: ap_ctrl, data_length and the 11-entry tap coefficient BRAM.
- Sits between the host/bench AXI-lite initiator and the FIR datapath engine.
- Decodes addresses, drives the tap BRAM port while the engine is idle, and generates ap_start to the engine. Reports ap_done/ap_idle back to the host.

---
 rtl/fir_axilite_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_fir_axilite_cfg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axilite_cfg.sv
// AXI-lite configuration responder for the FIR engine: ap_ctrl, data_length and
// the tap coefficient BRAM port, shared between host reads and host writes.
module fir_axilite_cfg #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [31:0]            data_length,
    output logic                   ap_start,
    input  logic                   engine_done
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_CTRL, SEL_LEN, SEL_TAP} sel_e;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'('h40);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'('h40 + 4 * (Tape_Num - 1));

    function automatic sel_e decode(input logic [pADDR_WIDTH-1:0] a);
        if (a == ADDR_CTRL)
            return SEL_CTRL;
        if (a == ADDR_LEN)
            return SEL_LEN;
        if (a >= TAP_BASE && a <= TAP_LAST && a[1:0] == 2'b00)
            return SEL_TAP;
        return SEL_NONE;
    endfunction

    w_state_e               w_state, w_next;
    r_state_e               r_state, r_next;
    sel_e                   w_sel, r_sel;
    logic [pADDR_WIDTH-1:0] w_addr, r_addr;
    logic                   ap_idle, ap_done;
    logic                   w_commit, wr_tap_commit, rd_tap_issue;
    logic                   rd_from_bram;
    logic [pDATA_WIDTH-1:0] rdata_q, rd_value;

    assign wr_tap_commit = w_commit && (w_sel == SEL_TAP) && ap_idle;
    assign rdata         = rdata_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next   = w_state;
        awready  = 1'b0;
        wready   = 1'b0;
        w_commit = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = axis_rst_n;
                if (awvalid)
                    w_next = W_ADDR;
            end
            W_ADDR: w_next = W_DATA;
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_commit = 1'b1;
                    w_next   = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // A tap read yields the BRAM port to a same-cycle tap write and retries from R_ADDR.
    always_comb begin
        r_next       = r_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rd_tap_issue = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = axis_rst_n;
                if (arvalid)
                    r_next = R_ADDR;
            end
            R_ADDR: begin
                if (r_sel == SEL_TAP && ap_idle) begin
                    if (!wr_tap_commit) begin
                        rd_tap_issue = 1'b1;
                        r_next       = R_WAIT;
                    end
                end else begin
                    r_next = R_WAIT;
                end
            end
            R_WAIT: r_next = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                if (rready)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_Di = '0;
        tap_A  = '0;
        if (wr_tap_commit) begin
            tap_EN = 1'b1;
            tap_WE = 4'hf;
            tap_Di = wdata;
            tap_A  = w_addr - TAP_BASE;
        end else if (rd_tap_issue) begin
            tap_EN = 1'b1;
            tap_A  = r_addr - TAP_BASE;
        end
    end

    always_comb begin
        rd_value = '0;
        unique case (r_sel)
            SEL_CTRL: rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
            SEL_LEN:  rd_value = pDATA_WIDTH'(data_length);
            SEL_TAP:  rd_value = rd_from_bram ? tap_Do : '1;
            default:  rd_value = '0;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_addr       <= '0;
            w_sel        <= SEL_NONE;
            r_addr       <= '0;
            r_sel        <= SEL_NONE;
            rd_from_bram <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (w_state == W_IDLE && awvalid) begin
                w_addr <= awaddr;
                w_sel  <= decode(awaddr);
            end
            if (r_state == R_IDLE && arvalid) begin
                r_addr <= araddr;
                r_sel  <= decode(araddr);
            end
            if (r_state == R_ADDR)
                rd_from_bram <= rd_tap_issue;
            if (r_state == R_WAIT)
                rdata_q <= rd_value;
        end
    end

    // engine_done is applied last so it wins over a same-cycle ap_done clear.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start    <= 1'b0;
            ap_idle     <= 1'b1;
            ap_done     <= 1'b0;
            data_length <= '0;
        end else begin
            ap_start <= 1'b0;
            if (w_commit && ap_idle) begin
                if (w_sel == SEL_CTRL && wdata[0]) begin
                    ap_start <= 1'b1;
                    ap_idle  <= 1'b0;
                    ap_done  <= 1'b0;
                end
                if (w_sel == SEL_LEN)
                    data_length <= 32'(wdata);
            end
            if (rvalid && rready && r_sel == SEL_CTRL)
                ap_done <= 1'b0;
            if (engine_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Directed bench for fir_axilite_cfg with a 1-cycle-latency tap BRAM model.
module tb_fir_axilite_cfg;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 50;
    localparam logic [31:0] TAPS [11] = '{32'h0, 32'hfffffff6, 32'hfffffff7, 32'h17, 32'h38,
                                          32'h3f, 32'h38, 32'h17, 32'hfffffff7, 32'hfffffff6, 32'h0};

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          awready, wready, arready, rvalid;
    logic [DW-1:0] rdata;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di, tap_Do;
    logic [AW-1:0] tap_A;
    logic [31:0]   data_length;
    logic          ap_start;
    logic          engine_done = 1'b0;

    fir_axilite_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_length(data_length), .ap_start(ap_start), .engine_done(engine_done)
    );

    always #5 axis_clk = ~axis_clk;

    logic [31:0] tap_mem [16];
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hf)
                tap_mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[5:2]];
        end
    end

    int unsigned   start_pulses = 0, tap_wr_cnt = 0, tap_en_cnt = 0;
    logic [AW-1:0] last_wr_a = '0;
    always @(posedge axis_clk) begin
        if (ap_start)
            start_pulses++;
        if (tap_EN)
            tap_en_cnt++;
        if (tap_EN && tap_WE == 4'hf) begin
            tap_wr_cnt++;
            last_wr_a = tap_A;
        end
    end

    int unsigned n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
        int unsigned n = 0;
        int unsigned m = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < LIMIT) begin
            @(negedge axis_clk);
            n++;
        end
        @(negedge axis_clk);
        awvalid = 1'b0;
        wdata   = d;
        wvalid  = 1'b1;
        while (!wready && m < LIMIT) begin
            @(negedge axis_clk);
            m++;
        end
        @(negedge axis_clk);
        wvalid = 1'b0;
        check("wr_handshake_timeout", 32'((n >= LIMIT) || (m >= LIMIT)), 0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int unsigned stall, input logic done_at_accept,
                            output logic [31:0] d, output int unsigned lat, output int unsigned unstable);
        int unsigned n = 0;
        araddr   = a;
        arvalid  = 1'b1;
        unstable = 0;
        while (!arready && n < LIMIT) begin
            @(negedge axis_clk);
            n++;
        end
        @(negedge axis_clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < LIMIT) begin
            @(negedge axis_clk);
            lat++;
        end
        if (n >= LIMIT)
            lat = LIMIT;
        d = rdata;
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge axis_clk);
            if (!rvalid || rdata !== d)
                unstable++;
        end
        rready      = 1'b1;
        engine_done = done_at_accept;
        @(negedge axis_clk);
        rready      = 1'b0;
        engine_done = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int unsigned lat, unst;
        axi_read(a, 0, 1'b0, d, lat, unst);
        check(tag, d, exp);
        check({tag, "_lat"}, lat, 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int unsigned lat, unst, s0, e0, w0;

        for (int unsigned i = 0; i < 16; i++)
            tap_mem[i] = '0;
        repeat (3) @(negedge axis_clk);
        check("rst_ready", {28'h0, awready, wready, arready, rvalid}, 0);
        check("rst_tap_en", {27'h0, tap_EN, tap_WE}, 0);
        check("rst_ap_start", 32'(ap_start), 0);
        check("rst_rdata", rdata, 0);
        check("rst_len", data_length, 0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        rd_chk("ctrl_after_rst", 12'h000, 32'h4);
        rd_chk("len_after_rst", 12'h010, 32'h0);
        rd_chk("tap0_fresh", 12'h040, 32'h0);
        rd_chk("tap10_fresh", 12'h068, 32'h0);

        axi_write(12'h010, 32'd600);
        for (int unsigned i = 0; i < 11; i++) begin
            axi_write(12'(32'h40 + 4 * i), TAPS[i]);
            check($sformatf("tap_A_%0d", i), 32'(last_wr_a), 4 * i);
        end
        for (int unsigned i = 0; i < 11; i++)
            rd_chk($sformatf("tap_rb_%0d", i), 12'(32'h40 + 4 * i), TAPS[i]);
        rd_chk("len_rb", 12'h010, 32'd600);

        s0 = start_pulses;
        axi_write(12'h000, 32'h1);
        repeat (3) @(negedge axis_clk);
        check("start_one_pulse", start_pulses - s0, 1);
        e0 = tap_en_cnt;
        rd_chk("ctrl_busy", 12'h000, 32'h0);
        axi_write(12'h044, 32'd99);
        axi_write(12'h010, 32'd5);
        axi_write(12'h000, 32'h1);
        rd_chk("tap_busy", 12'h044, 32'hffffffff);
        rd_chk("len_busy", 12'h010, 32'd600);
        check("tap_en_busy", tap_en_cnt - e0, 0);
        check("start_ignored_busy", start_pulses - s0, 1);

        engine_done = 1'b1;
        @(negedge axis_clk);
        engine_done = 1'b0;
        rd_chk("ctrl_done", 12'h000, 32'h6);
        rd_chk("ctrl_done_clr", 12'h000, 32'h4);
        rd_chk("tap1_kept", 12'h044, 32'hfffffff6);
        rd_chk("len_kept", 12'h010, 32'd600);

        fork
            axi_write(12'h040, 32'd77);
            begin
                @(negedge axis_clk);
                axi_read(12'h040, 5, 1'b0, d, lat, unst);
            end
        join
        check("arb_data", d, 32'd77);
        check("arb_lat", lat, 4);
        check("stall_unstable", unst, 0);
        rd_chk("tap0_new", 12'h040, 32'd77);

        axi_write(12'h000, 32'h1);
        repeat (2) @(negedge axis_clk);
        axi_read(12'h000, 0, 1'b1, d, lat, unst);
        check("setwin_rd", d, 32'h0);
        rd_chk("setwin_done", 12'h000, 32'h6);
        rd_chk("setwin_clr", 12'h000, 32'h4);

        w0 = tap_wr_cnt;
        axi_write(12'h06c, 32'd55);
        check("past_last_tap_wr", tap_wr_cnt - w0, 0);
        rd_chk("past_last_tap_rd", 12'h06c, 32'h0);

        awaddr  = 12'h010;
        awvalid = 1'b1;
        @(negedge axis_clk);
        awvalid = 1'b0;
        @(negedge axis_clk);
        check("w_data_phase", 32'(wready), 1);
        wdata  = 32'd123;
        wvalid = 1'b1;
        #1 axis_rst_n = 1'b0;
        #2 check("rst_mid_wready", 32'(wready), 0);
        @(negedge axis_clk);
        wvalid = 1'b0;
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("len_abort", data_length, 0);
        rd_chk("len_abort_rd", 12'h010, 32'h0);
        rd_chk("ctrl_abort", 12'h000, 32'h4);
        rd_chk("tap0_abort", 12'h040, 32'd77);

        w0 = tap_wr_cnt;
        axi_write(12'h200, 32'h1234);
        check("unmapped_len", data_length, 0);
        check("unmapped_tap_wr", tap_wr_cnt - w0, 0);
        rd_chk("unmapped_rd", 12'h200, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
